// File: rtl/seg7_pkg.sv
// Shared types, glyph table and hex decode helper for the seven-segment scan driver.
package seg7_pkg;

  // Segment vector {a,b,c,d,e,f,g}, bit 6 = a, active-low.
  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG7_BLANK = 7'b1111111;

  // Active-low glyphs for hex digits 0..F.
  localparam seg7_t SEG7_GLYPH [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Decode one hex nibble into its active-low glyph.
  function automatic seg7_t seg7_hex(input logic [3:0] hex);
    return SEG7_GLYPH[hex];
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] hex_i,
  output seg7_t      seg_o
);

  assign seg_o = seg7_hex(hex_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode seven-segment driver with a shadowed
// value, leading-zero suppression, per-digit decimal points and blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_en,
  input  logic                    blank,
  output seg7_t                   seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int DIV_W = (SCAN_DIV >= 2) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS >= 2) ? $clog2(NUM_DIGITS) : 1;

  if ((NUM_DIGITS < 1) || (NUM_DIGITS > 8)) begin : g_bad_num_digits
    $error("seg7_scan_driver: NUM_DIGITS must be in 1..8");
  end
  if (SCAN_DIV < 2) begin : g_bad_scan_div
    $error("seg7_scan_driver: SCAN_DIV must be at least 2");
  end

  logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]        dig_idx_q, dig_idx_d;
  logic [4*NUM_DIGITS-1:0] val_sh_q,  val_sh_d;
  logic [NUM_DIGITS-1:0]   dp_sh_q,   dp_sh_d;
  seg7_t                   seg_q,     seg_d;
  logic                    dp_q,      dp_d;
  logic [NUM_DIGITS-1:0]   an_q,      an_d;

  logic                    tc_s;
  logic [NUM_DIGITS-1:0]   suppress_s;
  logic [3:0]              cur_nib_s;
  logic                    cur_dp_s;
  logic                    cur_sup_s;
  seg7_t                   glyph_s;

  // Divider, digit index and shadow register next-state.
  always_comb begin
    tc_s = (div_cnt_q == DIV_W'(SCAN_DIV - 1));
    if (tc_s) begin
      div_cnt_d = '0;
      if (dig_idx_q == IDX_W'(NUM_DIGITS - 1)) begin
        dig_idx_d = '0;
      end else begin
        dig_idx_d = dig_idx_q + IDX_W'(1);
      end
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
      dig_idx_d = dig_idx_q;
    end
    if (load) begin
      val_sh_d = value;
      dp_sh_d  = dp_in;
    end else begin
      val_sh_d = val_sh_q;
      dp_sh_d  = dp_sh_q;
    end
  end

  // A digit above 0 goes dark when it and every digit to its left are zero.
  always_comb begin
    logic run_v;
    run_v      = 1'b1;
    suppress_s = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run_v         = run_v && (val_sh_q[4*i +: 4] == 4'h0);
      suppress_s[i] = (i > 0) && lz_en && run_v;
    end
  end

  // Select the nibble, decimal point and suppression flag of the scanned digit.
  always_comb begin
    cur_nib_s = 4'h0;
    cur_dp_s  = 1'b0;
    cur_sup_s = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      cur_nib_s = (dig_idx_q == IDX_W'(i)) ? val_sh_q[4*i +: 4] : cur_nib_s;
      cur_dp_s  = (dig_idx_q == IDX_W'(i)) ? dp_sh_q[i]         : cur_dp_s;
      cur_sup_s = (dig_idx_q == IDX_W'(i)) ? suppress_s[i]      : cur_sup_s;
    end
  end

  hex_to_seg7 u_hex_to_seg7 (
    .hex_i (cur_nib_s),
    .seg_o (glyph_s)
  );

  // Output register inputs; blanking overrides everything but keeps scanning.
  always_comb begin
    if (blank) begin
      seg_d = SEG7_BLANK;
      dp_d  = 1'b1;
      an_d  = '1;
    end else begin
      seg_d = cur_sup_s ? SEG7_BLANK : glyph_s;
      dp_d  = ~cur_dp_s;
      an_d  = ~(NUM_DIGITS'(1) << dig_idx_q);
    end
  end

  // All state and registered outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      dig_idx_q <= '0;
      val_sh_q  <= '0;
      dp_sh_q   <= '0;
      seg_q     <= SEG7_BLANK;
      dp_q      <= 1'b1;
      an_q      <= '1;
    end else begin
      div_cnt_q <= div_cnt_d;
      dig_idx_q <= dig_idx_d;
      val_sh_q  <= val_sh_d;
      dp_sh_q   <= dp_sh_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for an N-digit common-anode seven-segment display, built around a per-digit hex glyph decoder. It captures a packed hex value on a load strobe into a shadow register, then scans the digits one at a time at a programmable rate. Optional features are leading-zero suppression, per-digit decimal points and global blanking. It sits between the datapath, which presents binary or hex results, and the board display pins, and it replaces one decoder instance per digit.

## Interface
- `NUM_DIGITS`, default 4: number of digits scanned; legal range 1..8.
- `SCAN_DIV`, default 50000: clock cycles each digit stays enabled; legal when ≥ 2.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `value`  in  4*NUM_DIGITS  packed hex digits; bits [3:0] are digit 0 (rightmost).
- `load`  in  1  capture `value` and `dp_in` into the shadow registers.
- `dp_in`  in  NUM_DIGITS  decimal point request per digit; 1 = lit.
- `lz_en`  in  1  leading-zero suppression enable; level-sensitive, not shadowed.
- `blank`  in  1  force all digits dark; level-sensitive, not shadowed.
- `seg`  out  7  segments {a,b,c,d,e,f,g}, bit 6 = a, active-low.
- `dp`  out  1  decimal point, active-low.
- `an`  out  NUM_DIGITS  digit enables, active-low, one-hot-low while scanning.

## Operation
- **Glyphs.** 7-bit codes, active-low, for hex digits 0 through F:
  - 0–7: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111.
  - 8–F: 0000000, 0001100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.
  - BLANK is 1111111.
- **Shadow registers.** `val_sh` and `dp_sh` load from `value` and `dp_in` when `load`=1. Otherwise they hold. The display never shows a partially updated value.
- **Scan counter.** `div_cnt` counts 0..SCAN_DIV-1 and wraps. On its terminal count, `dig_idx` advances 0→1→…→NUM_DIGITS-1→0.
- **Single digit.** When NUM_DIGITS=1, `dig_idx` stays 0 and `an` is held at 0 (digit continuously enabled).
- **Leading-zero suppression.** Digit i, for i>0, is suppressed when `lz_en`=1 and `val_sh` digits i..NUM_DIGITS-1 are all 0. Digit 0 is never suppressed, so a value of 0 shows a single "0".
- **Decimal point on suppressed digits.** A suppressed digit shows `seg`=BLANK. Its decimal point still follows `dp_sh[i]`.
- **Blanking.** When `blank`=1: `seg`=1111111, `dp`=1, `an`=all ones. Scanning continues internally, so releasing `blank` resumes at the current `dig_idx`.
- **Output register.** `an`, `seg` and `dp` are registered from (`dig_idx`, `val_sh`, `dp_sh`, `lz_en`, `blank`).
- **Reset values.** `div_cnt`=0, `dig_idx`=0, `val_sh`=0, `dp_sh`=0, `seg`=1111111, `dp`=1, `an`=all ones.
- **Unsupported parameters.** Illegal parameter values stop elaboration with `$error`.

## Timing
- **Reset.** First active output is the cycle after `rst` deasserts: `an`=…1110 (digit 0), `seg`=0000001.
- **Load latency.** `load` sampled at edge t updates the shadow at t. The new glyph appears on `seg` at edge t+1 for the digit being scanned.
- **Digit advance.** A `div_cnt` terminal count at edge t updates `dig_idx` at t. `an` and `seg` move to the next digit at edge t+1. Each digit is active for exactly SCAN_DIV cycles.
- **Load and advance together.** If `load` and the terminal count occur in the same cycle, the next digit is shown with the new shadow value.
- **Level inputs.** `blank` and `lz_en` take effect one cycle after they are sampled.
- **Reset mid-scan.** Asserting `rst` at any cycle restores all reset values at that edge, regardless of `load`.
- **Ghosting.** No overlap and no gap: exactly one `an` bit is low on every non-blank, non-reset cycle.

## Structure
- **Package `seg7_pkg`.**
  - `seg7_t` (logic [6:0]).
  - Constants `SEG7_BLANK` and `SEG7_GLYPH[16]`.
  - Function `seg7_hex(input [3:0])`, returning `seg7_t`.
- **Sub-module `hex_to_seg7`.**
  - Combinational wrapper over `seg7_hex`.
  - Single instance, fed by the digit mux.
- **Top level.** Holds the divider, index counter, shadow registers, leading-zero logic and output register.

## Test plan
All scenarios use NUM_DIGITS=4 and SCAN_DIV=4.
1. **Reset.** Hold `rst` 3 cycles, then release → during reset `seg`=1111111, `an`=1111, `dp`=1; the next cycle shows `an`=1110, `seg`=0000001.
2. **Full scan.** Load `value`=16'h3A7F → `an` sequence 1110, 1101, 1011, 0111, each for 4 cycles; `seg` is 0111000, 0001111, 0001000, 0000110; the pattern repeats.
3. **Leading zeros.** `lz_en`=1, `value`=16'h0050 → digits 3 and 2 show BLANK, digit 1 shows 0100100, digit 0 shows 0000001. Then `value`=0 → only digit 0 is lit, showing 0000001.
4. **Load on terminal count.** Pulse `load` with 16'hFFFF on a terminal-count cycle while showing 16'h1111 → the next digit shows 0111000; no digit ever shows a mixed value.
5. **Blank and decimal points.** `dp_in`=4'b0100, then assert `blank` for 6 cycles → `dp`=0 only while `an`=1011; during `blank` all outputs are 1; after release the scan resumes at the expected digit.
6. **Reset mid-scan.** Assert `rst` while `dig_idx`=2 → the next edge gives reset values; after release the scan restarts at digit 0 with `val_sh`=0.
